// File: rtl/addition_pkg.sv
// Shared definitions for the signed adder blocks: result sizing and the
// serial accumulator's state encoding.
package addition_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_t;

    // One extra bit per doubling of the operand count keeps any sum exact.
    function automatic int out_width(input int width, input int n_inputs);
        return $clog2(n_inputs) + width;
    endfunction

endpackage

// File: rtl/sign_extend_add.sv
// Combinational OUT_WIDTH adder: accumulator plus a sign-extended signed
// WIDTH-bit operand. Shared by the serial reducers.
module sign_extend_add #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic [OUT_WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [OUT_WIDTH-1:0] sum_o
);

    logic [OUT_WIDTH-1:0] operand_ext;

    assign operand_ext = {{(OUT_WIDTH-WIDTH){operand_i[WIDTH-1]}}, operand_i};
    assign sum_o       = acc_i + operand_ext;

endmodule

// File: rtl/adder_tree_signed_serial_acc.sv
// Serial signed reducer: sums N_INPUTS signed samples arriving one per
// handshake and presents the exact frame sum as one result word.
module adder_tree_signed_serial_acc
    import addition_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int N_INPUTS  = 16,
    localparam int OUT_WIDTH = out_width(WIDTH, N_INPUTS),
    localparam int CNT_WIDTH = $clog2(N_INPUTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output acc_state_t           state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on state; out_valid/out_data hold until taken.
    acc_state_t           state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] sum;

    sign_extend_add #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_add (
        .acc_i     (acc_q),
        .operand_i (in_data),
        .sum_o     (sum)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            ACC: begin
                // clear wins over a sample offered in the same cycle
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(N_INPUTS - 1)) begin
                        out_data_d = sum;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign frame_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_adder_tree_signed_serial_acc.sv
// Bench for the serial signed accumulator: directed frames plus random
// frames checked against a plain integer sum model.
module tb_adder_tree_signed_serial_acc;
    import addition_pkg::*;

    localparam int WIDTH = 4;
    localparam int N     = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] frame_cnt;
    acc_state_t state_o;

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;
    int m_sum  = 0;
    bit m_done = 1'b0;
    int smp_q[$];

    adder_tree_signed_serial_acc #(.WIDTH(WIDTH), .N_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_cnt (frame_cnt),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int to_signed4(input int r);
        return (r > 7) ? r - 16 : r;
    endfunction

    // mode 0: 0..15 ramp, mode 1: constant v, mode 2: random
    task automatic fill(input int mode, input int v);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       smp_q.push_back(to_signed4(i));
                1:       smp_q.push_back(v);
                default: smp_q.push_back(to_signed4(int'($urandom_range(0, 15))));
            endcase
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sum  = 0;
        m_done = 1'b0;
    endtask

    // gap_mode 0: valid every cycle, 1: toggling, 2: random gaps.
    // hold: DONE cycles with out_ready=0 before the result is taken.
    task automatic play(input int gap_mode, input int hold, input int stop_after, input bit ack);
        int low_cnt = 0;
        int hold_left = hold;
        bit fin = 1'b0;
        bit acc_now;
        bit hs_now;
        int s = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("in_ready", int'(in_ready), m_done ? 0 : 1);
            chk("out_valid", int'(out_valid), m_done ? 1 : 0);
            chk("frame_cnt", int'(frame_cnt), m_cnt);
            chk("state", int'(state_o), m_done ? 1 : 0);
            if (m_done) chk("out_data", int'(out_data), m_sum & 255);
            if (!in_ready) low_cnt++;
            if (fin) begin
                chk("bubble", low_cnt, hold + 1);
                in_valid  = 1'b0;
                out_ready = 1'b0;
                return;
            end
            if (!m_done && m_cnt == stop_after) begin
                in_valid = 1'b0;
                return;
            end
            if (m_done && !ack) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
                return;
            end
            if (m_done) begin
                out_ready = (hold_left == 0);
                if (hold_left > 0) hold_left--;
                in_valid = 1'b1;
                in_data  = 4'($urandom_range(0, 15));
                hs_now   = out_ready;
                acc_now  = 1'b0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                case (gap_mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 2 == 0);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                if (smp_q.size() == 0) in_valid = 1'b0;
                s       = (smp_q.size() > 0) ? smp_q[0] : 0;
                in_data = in_valid ? 4'(s) : 4'bx;
                acc_now = in_valid;
                hs_now  = 1'b0;
            end
            @(posedge clk);
            if (acc_now) begin
                m_sum += s;
                m_cnt++;
                void'(smp_q.pop_front());
                if (m_cnt == N) m_done = 1'b1;
            end
            if (hs_now) begin
                model_reset();
                fin = 1'b1;
            end
        end
        checks++;
        errors++;
        $display("FAIL play_timeout observed=no_completion expected=completion");
    endtask

    initial begin
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        fill(0, 0);
        play(0, 0, N, 1'b1);
        chk("ramp_sum", int'(out_data), 8'hF8);

        fill(1, -8);
        play(0, 0, N, 1'b1);
        chk("min_sum", int'(out_data), 8'h80);

        fill(1, 0);
        play(1, 0, N, 1'b1);
        chk("zero_toggle_sum", int'(out_data), 0);

        fill(0, 0);
        play(0, 5, N, 1'b1);
        chk("held_sum", int'(out_data), 8'hF8);

        for (int i = 0; i < 7; i++) smp_q.push_back(7);
        play(0, 0, 7, 1'b1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd7;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_cnt", int'(frame_cnt), 0);
        chk("clear_ready", int'(in_ready), 1);
        model_reset();
        fill(1, 1);
        play(0, 0, N, 1'b1);
        chk("after_clear_sum", int'(out_data), 16);

        fill(1, 3);
        play(0, 0, 10, 1'b1);
        smp_q.delete();
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        fill(2, 0);
        play(2, 0, N, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("rst_done");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        fill(1, -1);
        play(0, 0, N, 1'b1);
        chk("neg_one_sum", int'(out_data), 8'hF0);

        for (int f = 0; f < 4; f++) begin
            fill(2, 0);
            play(2, int'($urandom_range(0, 3)), N, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
